// File: rtl/matrix_mult_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matrix_mult_pkg                                               |
// | Purpose  : Shared types and constants for the matrix_mult controller and |
// |            the code that drives or checks it.                            |
// |            - mm_ctrl_state_e : controller phase encoding                 |
// |            - c_*_DEFAULT     : default N / WIDTH / PIPE_STAGES           |
// |            - mm_latency()    : operand hold time before C is valid       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package matrix_mult_pkg;

   localparam int c_N_DEFAULT           = 4;
   localparam int c_WIDTH_DEFAULT       = 16;
   localparam int c_PIPE_STAGES_DEFAULT = 2;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } mm_ctrl_state_e;

   // Datapath settle time: multiplier pipeline, N-term accumulation, output register.
   function automatic int mm_latency(input int n, input int pipe);
      return pipe + n + 1;
   endfunction

endpackage : matrix_mult_pkg
`default_nettype wire

// File: rtl/matrix_mult_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matrix_mult_ctrl_if                                           |
// | Purpose  : Row-streaming interface of the matrix_mult controller.        |
// |            Input stream  : in_valid, in_ready, in_data  (A then B rows)  |
// |            Output stream : out_valid, out_ready, out_data, out_last (C)  |
// |            master = streaming fabric side, slave = controller side.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface matrix_mult_ctrl_if
   import matrix_mult_pkg::*;
#(
   parameter int N     = c_N_DEFAULT,
   parameter int WIDTH = c_WIDTH_DEFAULT
) ();

   logic                     in_valid;
   logic                     in_ready;
   logic [N*WIDTH-1:0]       in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [N*2*WIDTH-1:0]     out_data;
   logic                     out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface : matrix_mult_ctrl_if
`default_nettype wire

// File: rtl/matrix_mult_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matrix_mult_ctrl                                              |
// | Purpose  : Streaming sequencer for one N x N matrix_mult datapath.       |
// |            Loads A then B one row per beat, holds them on mm_a / mm_b,   |
// |            waits COMPUTE_CYCLES, then streams C out one row per beat.    |
// | Ports    : clk    - clock, rising edge                                   |
// |            rst_n  - synchronous active-low reset                         |
// |            bus    - row stream interface (slave modport)                 |
// |            busy   - high in LOAD_B, COMPUTE and DRAIN                    |
// |            mm_a   - A operand to datapath  [row][col]                    |
// |            mm_b   - B operand to datapath  [row][col]                    |
// |            mm_c   - C result from datapath [row][col]                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module matrix_mult_ctrl
   import matrix_mult_pkg::*;
#(
   parameter int N              = c_N_DEFAULT,
   parameter int WIDTH          = c_WIDTH_DEFAULT,
   parameter int PIPE_STAGES    = c_PIPE_STAGES_DEFAULT,
   parameter int COMPUTE_CYCLES = mm_latency(N, PIPE_STAGES)
) (
   input  wire logic                                   clk,
   input  wire logic                                   rst_n,
   matrix_mult_ctrl_if.slave                           bus,
   output      logic                                   busy,
   output      logic [N-1:0][N-1:0][WIDTH-1:0]         mm_a,
   output      logic [N-1:0][N-1:0][WIDTH-1:0]         mm_b,
   input  wire logic [N-1:0][N-1:0][2*WIDTH-1:0]       mm_c
);

   localparam int c_ROW_W  = $clog2(N);
   localparam int c_WAIT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

   localparam logic [c_ROW_W-1:0]  c_ROW_LAST  = c_ROW_W'(N - 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(COMPUTE_CYCLES - 1);

   localparam logic [1:0] c_ST_LOAD_A  = LOAD_A;
   localparam logic [1:0] c_ST_LOAD_B  = LOAD_B;
   localparam logic [1:0] c_ST_COMPUTE = COMPUTE;
   localparam logic [1:0] c_ST_DRAIN   = DRAIN;

   logic [1:0]                       r_state;
   logic [c_ROW_W-1:0]               r_row;
   logic [c_WAIT_W-1:0]              r_wait;
   logic [N-1:0][N-1:0][WIDTH-1:0]   r_mm_a;
   logic [N-1:0][N-1:0][WIDTH-1:0]   r_mm_b;

   logic                             w_loading;
   logic                             w_in_ready;
   logic                             w_out_valid;
   logic                             w_in_hs;
   logic                             w_out_hs;
   logic                             w_row_last;

   // Ready is forced low while reset is asserted so nothing is accepted
   // before the state register has been initialised.
   assign w_loading   = (r_state == c_ST_LOAD_A) || (r_state == c_ST_LOAD_B);
   assign w_in_ready  = rst_n && w_loading;
   assign w_out_valid = (r_state == c_ST_DRAIN);
   assign w_in_hs     = bus.in_valid && w_in_ready;
   assign w_out_hs    = w_out_valid && bus.out_ready;
   assign w_row_last  = (r_row == c_ROW_LAST);

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_last  = w_out_valid && w_row_last;
   // mm_c is stable throughout DRAIN because the operands are frozen.
   assign bus.out_data  = mm_c[r_row];
   assign busy          = (r_state != c_ST_LOAD_A);
   assign mm_a          = r_mm_a;
   assign mm_b          = r_mm_b;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_ST_LOAD_A;
         r_row   <= '0;
         r_wait  <= '0;
         r_mm_a  <= '0;
         r_mm_b  <= '0;
      end else begin
         case (r_state)
            c_ST_LOAD_A: begin
               if (w_in_hs) begin
                  r_mm_a[r_row] <= bus.in_data;
                  if (w_row_last) begin
                     r_row   <= '0;
                     r_state <= c_ST_LOAD_B;
                  end else begin
                     r_row <= r_row + c_ROW_W'(1);
                  end
               end
            end

            c_ST_LOAD_B: begin
               if (w_in_hs) begin
                  r_mm_b[r_row] <= bus.in_data;
                  if (w_row_last) begin
                     r_row   <= '0;
                     r_wait  <= c_WAIT_INIT;
                     r_state <= c_ST_COMPUTE;
                  end else begin
                     r_row <= r_row + c_ROW_W'(1);
                  end
               end
            end

            c_ST_COMPUTE: begin
               if (r_wait == '0) begin
                  r_row   <= '0;
                  r_state <= c_ST_DRAIN;
               end else begin
                  r_wait <= r_wait - c_WAIT_W'(1);
               end
            end

            c_ST_DRAIN: begin
               if (w_out_hs) begin
                  if (w_row_last) begin
                     r_row   <= '0;
                     r_state <= c_ST_LOAD_A;
                  end else begin
                     r_row <= r_row + c_ROW_W'(1);
                  end
               end
            end

            default: begin
               r_row   <= '0;
               r_state <= c_ST_LOAD_A;
            end
         endcase
      end
   end

endmodule : matrix_mult_ctrl
`default_nettype wire

// File: tb/tb_matrix_mult_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_matrix_mult_ctrl                                           |
// | Purpose  : Self-checking bench for matrix_mult_ctrl. A behavioural       |
// |            matrix product stands in for the datapath; expected C comes   |
// |            from table constants or from the reference product of the     |
// |            matrices the bench itself streamed in.                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_matrix_mult_ctrl;
   import matrix_mult_pkg::*;

   localparam int N  = c_N_DEFAULT;
   localparam int W  = c_WIDTH_DEFAULT;
   localparam int P  = c_PIPE_STAGES_DEFAULT;
   localparam int CC = mm_latency(N, P);

   typedef logic [N-1:0][N-1:0][W-1:0]   mat_t;
   typedef logic [N-1:0][N-1:0][2*W-1:0] cmat_t;

   typedef struct {
      string name;
      mat_t  a;
      mat_t  b;
      cmat_t c;
      int    bp_row;
      int    bp_len;
      bit    poke;
   } vec_t;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b0;
   logic  busy;
   mat_t  mm_a;
   mat_t  mm_b;
   cmat_t mm_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   matrix_mult_ctrl_if #(.N(N), .WIDTH(W)) bus ();

   matrix_mult_ctrl #(
      .N(N), .WIDTH(W), .PIPE_STAGES(P), .COMPUTE_CYCLES(CC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
      .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c)
   );

   // Reference product, mod 2^(2W), from plain integer arithmetic.
   function automatic cmat_t matmul(input mat_t a, input mat_t b);
      cmat_t  r;
      longint s;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++)
               s += longint'(a[i][k]) * longint'(b[k][j]);
            r[i][j] = s[2*W-1:0];
         end
      return r;
   endfunction

   // Behavioural stand-in for the attached datapath.
   assign mm_c = matmul(mm_a, mm_b);

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one row, optionally after an idle gap; returns just after the
   // edge that accepted it.
   task automatic send_row(input logic [N*W-1:0] d, input int gap_pct);
      int  cnt;
      bit  hs;
      if ($urandom_range(0, 99) < gap_pct) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      cnt = 0;
      forever begin
         hs = bus.in_ready;
         tick();
         if (hs) break;
         cnt++;
         if (cnt > 100) begin
            chk("in_handshake_timeout", 256'(cnt), 256'(0));
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic run_job(input string name, input mat_t a, input mat_t b, input cmat_t c,
                          input int gap_pct, input int bp_row, input int bp_len,
                          input bit rand_bp, input bit poke);
      int cnt;
      int stall;
      bit saw_ready;
      for (int r = 0; r < N; r++) send_row(a[r], gap_pct);
      for (int r = 0; r < N; r++) send_row(b[r], gap_pct);
      chk({name, ":mm_a"}, 256'(mm_a), 256'(a));
      chk({name, ":mm_b"}, 256'(mm_b), 256'(b));
      chk({name, ":busy_compute"}, 256'(busy), 256'(1));

      // Handshake cycle counts as 0; the current cycle is 1.
      if (poke) begin
         bus.in_valid = 1'b1;
         bus.in_data  = $urandom();
      end
      cnt       = 1;
      saw_ready = 1'b0;
      while (!bus.out_valid && cnt < 200) begin
         if (bus.in_ready) saw_ready = 1'b1;
         tick();
         cnt++;
      end
      bus.in_valid = 1'b0;
      chk({name, ":latency"}, 256'(cnt), 256'(CC + 1));
      chk({name, ":in_ready_compute"}, 256'(saw_ready), 256'(0));
      if (poke) chk({name, ":mm_a_held"}, 256'(mm_a), 256'(a));

      for (int r = 0; r < N; r++) begin
         stall = (r == bp_row) ? bp_len : (rand_bp ? int'($urandom_range(0, 2)) : 0);
         bus.out_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            chk($sformatf("%s:stall_data_r%0d", name, r), 256'(bus.out_data), 256'(c[r]));
            chk($sformatf("%s:stall_in_ready_r%0d", name, r), 256'(bus.in_ready), 256'(0));
            tick();
         end
         bus.out_ready = 1'b1;
         chk($sformatf("%s:out_valid_r%0d", name, r), 256'(bus.out_valid), 256'(1));
         chk($sformatf("%s:out_data_r%0d", name, r), 256'(bus.out_data), 256'(c[r]));
         chk($sformatf("%s:out_last_r%0d", name, r), 256'(bus.out_last), 256'(r == N - 1));
         tick();
      end
      bus.out_ready = 1'b0;
      chk({name, ":in_ready_after"}, 256'(bus.in_ready), 256'(1));
      chk({name, ":out_valid_after"}, 256'(bus.out_valid), 256'(0));
      chk({name, ":busy_after"}, 256'(busy), 256'(0));
   endtask

   task automatic check_reset_state(input string name);
      chk({name, ":in_ready"}, 256'(bus.in_ready), 256'(0));
      chk({name, ":out_valid"}, 256'(bus.out_valid), 256'(0));
      chk({name, ":out_last"}, 256'(bus.out_last), 256'(0));
      chk({name, ":busy"}, 256'(busy), 256'(0));
      chk({name, ":mm_a"}, 256'(mm_a), 256'(0));
      chk({name, ":mm_b"}, 256'(mm_b), 256'(0));
   endtask

   vec_t vecs[3];

   initial begin
      mat_t  ra;
      mat_t  rb;

      // Table: identity x B, uniform 2*3, overflow 0xFFFF*0xFFFF.
      vecs[0].name = "identity"; vecs[0].bp_row = -1; vecs[0].bp_len = 0; vecs[0].poke = 1'b0;
      vecs[1].name = "uniform";  vecs[1].bp_row = 1;  vecs[1].bp_len = 5; vecs[1].poke = 1'b0;
      vecs[2].name = "overflow"; vecs[2].bp_row = -1; vecs[2].bp_len = 0; vecs[2].poke = 1'b1;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            vecs[0].a[i][j] = (i == j) ? 16'd1 : 16'd0;
            vecs[0].b[i][j] = 16'(i * N + j + 1);
            vecs[0].c[i][j] = 32'(i * N + j + 1);
            vecs[1].a[i][j] = 16'd2;
            vecs[1].b[i][j] = 16'd3;
            vecs[1].c[i][j] = 32'd24;
            vecs[2].a[i][j] = 16'hFFFF;
            vecs[2].b[i][j] = 16'hFFFF;
            vecs[2].c[i][j] = 32'hFFF8_0004;
         end

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset state.
      tick();
      tick();
      check_reset_state("reset");
      rst_n = 1'b1;
      tick();
      chk("reset:in_ready_after_release", 256'(bus.in_ready), 256'(1));

      // Table jobs, back to back.
      for (int v = 0; v < 3; v++)
         run_job(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].c, 0,
                 vecs[v].bp_row, vecs[v].bp_len, 1'b0, vecs[v].poke);

      // Input gaps must not change the result.
      run_job("gaps", vecs[1].a, vecs[1].b, vecs[1].c, 60, -1, 0, 1'b0, 1'b0);

      // Reset in the middle of LOAD_B after two B rows.
      for (int r = 0; r < N; r++) send_row(vecs[1].a[r], 0);
      for (int r = 0; r < 2; r++) send_row(vecs[1].b[r], 0);
      chk("midreset:busy_before", 256'(busy), 256'(1));
      rst_n = 1'b0;
      tick();
      check_reset_state("midreset");
      rst_n = 1'b1;
      tick();
      chk("midreset:in_ready_after", 256'(bus.in_ready), 256'(1));
      run_job("post_reset", vecs[0].a, vecs[0].b, vecs[0].c, 0, -1, 0, 1'b0, 1'b0);

      // Random jobs against the reference product.
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ra[i][j] = 16'($urandom());
               rb[i][j] = 16'($urandom());
            end
         run_job($sformatf("random%0d", t), ra, rb, matmul(ra, rb), 30, -1, 0, 1'b1, t[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1);
   end

endmodule : tb_matrix_mult_ctrl
`default_nettype wire

// File: doc/matrix_mult_ctrl.md
# matrix_mult_ctrl

Streaming sequencer for the N×N `matrix_mult` datapath.
- Accepts A and B one row per beat over a valid/ready input stream and holds them stable on the datapath operand buses.
- Waits the datapath's fixed settle latency, then returns C one row per beat over a valid/ready output stream.
- Sits between the system streaming fabric and one `matrix_mult` instance; jobs are processed strictly one at a time.

## Interface
- N, 4, matrix dimension (N ≥ 2)
- WIDTH, 16, operand element width
- PIPE_STAGES, 2, multiplier pipeline depth of the attached datapath
- COMPUTE_CYCLES, PIPE_STAGES+N+1, cycles operands are held before C is sampled (must be ≥ 1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input row beat valid
- in_ready  out  1  controller accepts a row this cycle
- in_data  in  N*WIDTH  row; column c at bits [(c+1)*WIDTH-1 : c*WIDTH]
- out_valid  out  1  C row beat valid
- out_ready  in  1  downstream accepts a C row
- out_data  out  N*2*WIDTH  C row; column c at bits [(c+1)*2*WIDTH-1 : c*2*WIDTH]
- out_last  out  1  high with row N-1 of C
- busy  out  1  high in LOAD_B, COMPUTE and DRAIN
- mm_a  out  [N][N]×WIDTH  A operand to datapath
- mm_b  out  [N][N]×WIDTH  B operand to datapath
- mm_c  in  [N][N]×2*WIDTH  C result from datapath

## Operation
- States: LOAD_A, LOAD_B, COMPUTE, DRAIN. A row counter (0..N-1) and a wait counter (0..COMPUTE_CYCLES-1) are held.
- LOAD_A:
  - in_ready = 1.
  - Each handshake (in_valid && in_ready) writes in_data to mm_a[row], then row++.
  - On the handshake at row N-1: row ← 0, go to LOAD_B.
- LOAD_B: identical to LOAD_A but writes mm_b. On the handshake at row N-1: wait ← COMPUTE_CYCLES-1, go to COMPUTE.
- COMPUTE:
  - in_ready = 0; mm_a and mm_b are held.
  - Decrement wait each cycle. When wait == 0: row ← 0, go to DRAIN.
- DRAIN:
  - out_valid = 1; out_data = mm_c[row] (combinational mux); out_last = (row == N-1).
  - Each handshake (out_valid && out_ready) increments row.
  - On the handshake at row N-1: row ← 0, go to LOAD_A.
- mm_a and mm_b change only on LOAD handshakes. They stay unchanged through COMPUTE and DRAIN, so mm_c is stable while draining.
- Arithmetic is done by the datapath. The controller passes C through unmodified; values are the datapath's mod 2^(2*WIDTH) sums.
- in_ready and out_valid are never both high. Input and output never overlap.

## Timing
- Reset (rst_n low at a clk edge):
  - state ← LOAD_A; row ← 0; wait ← 0.
  - mm_a and mm_b ← 0; out_valid = 0; busy = 0; out_last = 0.
  - in_ready = 0 while rst_n is low. in_ready = 1 from the first cycle after rst_n is high.
- Reset mid-job discards all loaded rows and any undrained C. No partial output is emitted.
- in_ready and out_valid are pure functions of the state. in_ready does not depend on in_valid; out_valid does not depend on out_ready.
- Load takes a minimum of 2N cycles with in_valid held high. Gaps in in_valid stall the row counter.
- First out_valid occurs exactly COMPUTE_CYCLES+1 cycles after the clock edge that accepted the last B row.
- out_ready low holds out_data and row unchanged, with no timeout.
- After the last C handshake, in_ready is 1 in the very next cycle. Back-to-back jobs have zero bubble beyond COMPUTE.
- out_valid held high with out_ready low in DRAIN is legal indefinitely.
- in_valid asserted during COMPUTE/DRAIN is ignored; the data is not consumed.

## Structure
- Shared package `matrix_mult_pkg` holds:
  - the state enum `mm_ctrl_state_e` (LOAD_A, LOAD_B, COMPUTE, DRAIN);
  - the default N, WIDTH and PIPE_STAGES constants;
  - a function `mm_latency(n, pipe)` returning pipe+n+1, used by both this block and the bench.
- No sub-module. The controller and `matrix_mult` are paired in the enclosing top level, with mm_a→A, mm_b→B and C→mm_c.
- Counters and the row mux are inline.

## Test plan
- Identity × B: A = I, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} → C rows equal B. out_last is high only on the 4th beat. First out_valid is 8 cycles after the last B handshake (defaults).
- Uniform: A all 2, B all 3 → every C element = 24.
- Overflow: A and B all 0xFFFF → every C element = 0xFFF80004 (wraps mod 2^32).
- Backpressure: hold out_ready low for 5 cycles on row 1 → out_data stays on row 1, and row 2 follows only after the handshake. Random in_valid gaps → the same C as the uniform case.
- Reset mid-LOAD_B after 2 B rows → all outputs return to reset values. A fresh job then produces correct C with no stale rows.
- Back-to-back jobs: identity job, then the uniform job → in_ready is high the cycle after the first job's last C beat, and the second job's C = 24s.
